// File: rtl/sync_lane_sprite.sv
// Lane timing-plus-motion block: delays HSync/VSync, regenerates pixel/tile counters, and moves one lane object.
// Optional build macro LANE_PAUSE_EN adds i_Enable to freeze the object's motion.
module sync_lane_sprite #(
    parameter int unsigned TOTAL_COLS   = 800,
    parameter int unsigned TOTAL_ROWS   = 525,
    parameter int unsigned c_SPEED      = 1,
    parameter int unsigned c_DIR        = 0,
    parameter int unsigned c_MIN_X      = 0,
    parameter int unsigned c_MAX_X      = 14,
    parameter int unsigned c_SLOW_COUNT = 4000000,
    parameter int unsigned c_INIT_X     = 0,
    parameter int unsigned c_INIT_Y     = 11
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
`ifdef LANE_PAUSE_EN
    input  logic       i_Enable,
`endif
    input  logic       i_HSync,
    input  logic       i_VSync,
    output logic       o_HSync,
    output logic       o_VSync,
    output logic [9:0] o_Col_Count,
    output logic [9:0] o_Row_Count,
    output logic [4:0] o_Col_Count_Div,
    output logic [4:0] o_Row_Count_Div,
    output logic [5:0] o_Obj_X,
    output logic [5:0] o_Obj_Y,
    output logic       o_Step,
    output logic       o_Draw
);

    localparam int unsigned CNT_W   = 10;
    localparam int unsigned POS_W   = 6;
    localparam int unsigned ARITH_W = 7;
    localparam int unsigned TICK_W  = 32;

    logic                 enable;
    logic                 frame_start;
    logic [CNT_W-1:0]     col_next;
    logic [CNT_W-1:0]     row_next;
    logic [TICK_W-1:0]    tick;
    logic                 tick_last;
    logic                 step_now;
    logic [ARITH_W-1:0]   x_ext;
    logic [ARITH_W-1:0]   x_sum;
    logic [POS_W-1:0]     x_next;

`ifdef LANE_PAUSE_EN
    assign enable = i_Enable;
`else
    assign enable = 1'b1;
`endif

    // Frame start is a VSync rising edge seen against the delayed copy.
    assign frame_start = i_VSync & ~o_VSync;

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            o_HSync <= 1'b0;
            o_VSync <= 1'b0;
        end else begin
            o_HSync <= i_HSync;
            o_VSync <= i_VSync;
        end
    end

    // Raster counter next-state: frame start beats line wrap beats increment.
    always_comb begin
        col_next = o_Col_Count + CNT_W'(1);
        row_next = o_Row_Count;
        if (frame_start) begin
            col_next = '0;
            row_next = '0;
        end else if (o_Col_Count == CNT_W'(TOTAL_COLS - 1)) begin
            col_next = '0;
            if (o_Row_Count == CNT_W'(TOTAL_ROWS - 1)) begin
                row_next = '0;
            end else begin
                row_next = o_Row_Count + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            o_Col_Count <= '0;
            o_Row_Count <= '0;
        end else begin
            o_Col_Count <= col_next;
            o_Row_Count <= row_next;
        end
    end

    assign o_Col_Count_Div = o_Col_Count[9:5];
    assign o_Row_Count_Div = o_Row_Count[9:5];

    assign tick_last = (tick == TICK_W'(c_SLOW_COUNT - 1));
    assign step_now  = enable & tick_last;

    // Wrapping step computed one bit wider so neither sum nor difference aliases.
    always_comb begin
        x_ext  = {1'b0, o_Obj_X};
        x_sum  = x_ext + ARITH_W'(c_SPEED);
        x_next = o_Obj_X;
        if (c_DIR == 0) begin
            if (x_sum >= ARITH_W'(c_MAX_X)) begin
                x_next = POS_W'(c_MIN_X);
            end else begin
                x_next = POS_W'(x_sum);
            end
        end else begin
            if (x_ext < ARITH_W'(c_MIN_X + c_SPEED)) begin
                x_next = POS_W'(c_MAX_X - 1);
            end else begin
                x_next = POS_W'(x_ext - ARITH_W'(c_SPEED));
            end
        end
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            tick    <= '0;
            o_Obj_X <= POS_W'(c_INIT_X);
            o_Obj_Y <= POS_W'(c_INIT_Y);
            o_Step  <= 1'b0;
        end else begin
            o_Step <= step_now;
            if (enable) begin
                tick <= tick_last ? '0 : tick + TICK_W'(1);
            end
            if (step_now) begin
                o_Obj_X <= x_next;
            end
        end
    end

    assign o_Draw = ({1'b0, o_Col_Count_Div} == o_Obj_X) &&
                    ({1'b0, o_Row_Count_Div} == o_Obj_Y);

endmodule

// File: tb/tb_sync_lane_sprite.sv
// Randomised bench for sync_lane_sprite: a rightward lane, a leftward lane and a draw-test lane,
// all checked against a position-count reference model.
module tb_sync_lane_sprite;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic hs  = 1'b0;
    logic vs  = 1'b0;
    logic en  = 1'b1;

    always #5 clk = ~clk;

    logic       a_hs, a_vs, a_step, a_draw;
    logic [9:0] a_col, a_row;
    logic [4:0] a_cdiv, a_rdiv;
    logic [5:0] a_x, a_y;
    logic       b_hs, b_vs, b_step, b_draw;
    logic [9:0] b_col, b_row;
    logic [4:0] b_cdiv, b_rdiv;
    logic [5:0] b_x, b_y;
    logic       c_hs, c_vs, c_step, c_draw;
    logic [9:0] c_col, c_row;
    logic [4:0] c_cdiv, c_rdiv;
    logic [5:0] c_x, c_y;

    sync_lane_sprite #(.TOTAL_COLS(8), .TOTAL_ROWS(4), .c_SPEED(1), .c_DIR(0), .c_MIN_X(0),
                       .c_MAX_X(14), .c_SLOW_COUNT(4), .c_INIT_X(12), .c_INIT_Y(11)) u_right (
        .i_Clk(clk), .i_Rst(rst),
`ifdef LANE_PAUSE_EN
        .i_Enable(en),
`endif
        .i_HSync(hs), .i_VSync(vs), .o_HSync(a_hs), .o_VSync(a_vs),
        .o_Col_Count(a_col), .o_Row_Count(a_row), .o_Col_Count_Div(a_cdiv), .o_Row_Count_Div(a_rdiv),
        .o_Obj_X(a_x), .o_Obj_Y(a_y), .o_Step(a_step), .o_Draw(a_draw));

    sync_lane_sprite #(.TOTAL_COLS(8), .TOTAL_ROWS(4), .c_SPEED(1), .c_DIR(1), .c_MIN_X(0),
                       .c_MAX_X(14), .c_SLOW_COUNT(4), .c_INIT_X(1), .c_INIT_Y(11)) u_left (
        .i_Clk(clk), .i_Rst(rst),
`ifdef LANE_PAUSE_EN
        .i_Enable(en),
`endif
        .i_HSync(hs), .i_VSync(vs), .o_HSync(b_hs), .o_VSync(b_vs),
        .o_Col_Count(b_col), .o_Row_Count(b_row), .o_Col_Count_Div(b_cdiv), .o_Row_Count_Div(b_rdiv),
        .o_Obj_X(b_x), .o_Obj_Y(b_y), .o_Step(b_step), .o_Draw(b_draw));

    sync_lane_sprite #(.TOTAL_COLS(100), .TOTAL_ROWS(360), .c_SLOW_COUNT(200000),
                       .c_INIT_X(2), .c_INIT_Y(11)) u_draw (
        .i_Clk(clk), .i_Rst(rst),
`ifdef LANE_PAUSE_EN
        .i_Enable(en),
`endif
        .i_HSync(hs), .i_VSync(vs), .o_HSync(c_hs), .o_VSync(c_vs),
        .o_Col_Count(c_col), .o_Row_Count(c_row), .o_Col_Count_Div(c_cdiv), .o_Row_Count_Div(c_rdiv),
        .o_Obj_X(c_x), .o_Obj_Y(c_y), .o_Step(c_step), .o_Draw(c_draw));

    wire [45:0] obs_a = {a_hs, a_vs, a_col, a_row, a_cdiv, a_rdiv, a_x, a_y, a_step, a_draw};
    wire [45:0] obs_b = {b_hs, b_vs, b_col, b_row, b_cdiv, b_rdiv, b_x, b_y, b_step, b_draw};
    wire [45:0] obs_c = {c_hs, c_vs, c_col, c_row, c_cdiv, c_rdiv, c_x, c_y, c_step, c_draw};

    int errors = 0;
    int checks = 0;

    // Reference model: raster as a linear pixel index since frame start, motion as enabled-edge count.
    int   p, pc, ticks, xa, xb;
    bit   stp;
    logic mhs, mvs;

    task automatic model_reset();
        p = 0; pc = 0; ticks = 0; xa = 12; xb = 1; stp = 0; mhs = 0; mvs = 0;
    endtask

    task automatic model_edge();
        bit frame;
        if (rst) begin
            model_reset();
        end else begin
            frame = vs && !mvs;
            mhs = hs;
            mvs = vs;
            p  = frame ? 0 : (p + 1) % 32;
            pc = frame ? 0 : (pc + 1) % 36000;
            stp = 0;
            if (en) begin
                ticks++;
                if (ticks % 4 == 0) begin
                    stp = 1;
                    xa = (xa + 1) % 14;
                    xb = (xb + 13) % 14;
                end
            end
        end
    endtask

    function automatic logic [45:0] exp_lane(input int cols, input int rows, input int pix,
                                             input int x, input bit s);
        int col, row;
        bit draw;
        col  = pix % cols;
        row  = (pix / cols) % rows;
        draw = (col / 32 == x) && (row / 32 == 11);
        return {mhs, mvs, 10'(col), 10'(row), 5'(col / 32), 5'(row / 32), 6'(x), 6'(11), s, draw};
    endfunction

    function automatic logic [45:0] exp_a(); return exp_lane(8, 4, p, xa, stp); endfunction
    function automatic logic [45:0] exp_b(); return exp_lane(8, 4, p, xb, stp); endfunction
    function automatic logic [45:0] exp_c(); return exp_lane(100, 360, pc, 2, 1'b0); endfunction

    task automatic step_cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step_cycle();
        step_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            rst = 1'b1;
            hs = 1'($urandom);
            vs = 1'($urandom);
            step_cycle();
            checks++;
            if (obs_a !== exp_a()) begin errors++; $display("FAIL reset_a: got %h want %h", obs_a, exp_a()); end
            checks++;
            if (obs_b !== exp_b()) begin errors++; $display("FAIL reset_b: got %h want %h", obs_b, exp_b()); end
            checks++;
            if (obs_c !== exp_c()) begin errors++; $display("FAIL reset_c: got %h want %h", obs_c, exp_c()); end
        end
    endtask

    task automatic test_sync_delay();
        logic prev;
        rst = 1'b0;
        vs = 1'b0;
        for (int i = 0; i < 12; i++) begin
            prev = hs;
            hs = ~hs;
            checks++;
            if (a_hs !== prev) begin errors++; $display("FAIL hsync_early: got %b want %b", a_hs, prev); end
            step_cycle();
            checks++;
            if (a_hs !== hs) begin errors++; $display("FAIL hsync_delay: got %b want %b", a_hs, hs); end
        end
    endtask

    task automatic test_counter_wrap();
        vs = 1'b0;
        for (int i = 0; i < 70; i++) begin
            hs = 1'($urandom);
            step_cycle();
            checks++;
            if (obs_a !== exp_a()) begin errors++; $display("FAIL wrap_a: got %h want %h", obs_a, exp_a()); end
        end
        for (int i = 0; i < 8 && (p % 8) != 3; i++) step_cycle();
        vs = 1'b1;
        step_cycle();
        checks++;
        if ({a_col, a_row} !== 20'd0) begin
            errors++; $display("FAIL vsync_restart: got col %0d row %0d want 0 0", a_col, a_row);
        end
        for (int i = 0; i < 12; i++) begin
            if (i == 6) vs = 1'b0;
            step_cycle();
            checks++;
            if (obs_b !== exp_b()) begin errors++; $display("FAIL vsync_hold_b: got %h want %h", obs_b, exp_b()); end
        end
    endtask

    task automatic test_right_wrap();
        int seq [4] = '{12, 13, 0, 1};
        do_reset();
        vs = 1'b0;
        for (int n = 1; n <= 16; n++) begin
            step_cycle();
            checks++;
            if (obs_a !== exp_a()) begin errors++; $display("FAIL right_a: got %h want %h", obs_a, exp_a()); end
            if (n < 16) begin
                checks++;
                if (a_x !== 6'(seq[n / 4]) || a_step !== (n % 4 == 0)) begin
                    errors++; $display("FAIL right_seq: got x %0d step %b want x %0d", a_x, a_step, seq[n / 4]);
                end
            end
        end
    endtask

    task automatic test_left_wrap();
        int seq [4] = '{1, 0, 13, 12};
        do_reset();
        for (int n = 1; n <= 16; n++) begin
            hs = 1'($urandom);
            step_cycle();
            checks++;
            if (obs_b !== exp_b()) begin errors++; $display("FAIL left_b: got %h want %h", obs_b, exp_b()); end
            if (n < 16) begin
                checks++;
                if (b_x !== 6'(seq[n / 4]) || b_step !== (n % 4 == 0)) begin
                    errors++; $display("FAIL left_seq: got x %0d step %b want x %0d", b_x, b_step, seq[n / 4]);
                end
            end
        end
    endtask

    task automatic test_draw();
        int hits = 0;
        do_reset();
        vs = 1'b0;
        while (pc != 352 * 100 + 56) step_cycle();
        for (int i = 0; i < 44; i++) begin
            hs = 1'($urandom);
            step_cycle();
            checks++;
            if (obs_c !== exp_c()) begin errors++; $display("FAIL draw_c: got %h want %h", obs_c, exp_c()); end
            if (c_draw === 1'b1) hits++;
        end
        checks++;
        if (hits != 32) begin errors++; $display("FAIL draw_width: got %0d want 32", hits); end
    endtask

    task automatic test_random_reset();
        for (int i = 0; i < 400; i++) begin
            hs = 1'($urandom);
            if ($urandom_range(0, 15) == 0) vs = ~vs;
            if (!rst && $urandom_range(0, 59) == 0) begin
                rst = 1'b1;
                #1;
                checks++;
                if ({a_x, a_col, a_row, a_step, b_x} !== {6'd12, 10'd0, 10'd0, 1'b0, 6'd1}) begin
                    errors++; $display("FAIL async_reset: got x %0d col %0d step %b", a_x, a_col, a_step);
                end
            end else begin
                rst = 1'b0;
            end
            step_cycle();
            checks++;
            if (obs_a !== exp_a()) begin errors++; $display("FAIL random_a: got %h want %h", obs_a, exp_a()); end
            checks++;
            if (obs_b !== exp_b()) begin errors++; $display("FAIL random_b: got %h want %h", obs_b, exp_b()); end
        end
        rst = 1'b0;
    endtask

`ifdef LANE_PAUSE_EN
    task automatic test_pause();
        do_reset();
        for (int i = 0; i < 36; i++) begin
            en = (i >= 6 && i < 16) || (i >= 22 && i < 27) ? 1'b0 : 1'b1;
            hs = 1'($urandom);
            step_cycle();
            checks++;
            if (obs_a !== exp_a()) begin errors++; $display("FAIL pause_a: got %h want %h", obs_a, exp_a()); end
            checks++;
            if (obs_b !== exp_b()) begin errors++; $display("FAIL pause_b: got %h want %h", obs_b, exp_b()); end
        end
        en = 1'b1;
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_sync_delay();
        test_counter_wrap();
        test_right_wrap();
        test_left_wrap();
        test_draw();
        test_random_reset();
`ifdef LANE_PAUSE_EN
        test_pause();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sync_lane_sprite.md
Name: sync_lane_sprite

Overview:
- Per-lane timing-plus-motion block for the Frogger VGA datapath.
- Takes the incoming HSync/VSync pair, regenerates pixel column/row counters and 32-pixel tile indices, and owns one moving lane object (car or floating log).
- The object steps one or more tiles, right or left, at a slow programmable rate with wrap-around, and raises a draw flag when the raster is on its tile.
- Sits between the VGA sync generator and the game renderer/collision logic.

Parameters:
- TOTAL_COLS, 800, total columns per line including blanking.
- TOTAL_ROWS, 525, total rows per frame including blanking.
- c_SPEED, 1, tiles moved per step.
- c_DIR, 0, movement direction: 0 = rightward (car), 1 = leftward (log).
- c_MIN_X, 0, lowest legal tile X.
- c_MAX_X, 14, exclusive upper tile bound; legal X range is c_MIN_X..c_MAX_X-1.
- c_SLOW_COUNT, 4000000, clocks per movement step; must be at least 1.
- c_INIT_X, 0, tile X after reset.
- c_INIT_Y, 11, fixed lane tile row.

Ports:
- i_Clk  in  1  pixel clock; the only clock.
- i_Rst  in  1  asynchronous, active-high reset.
- i_HSync  in  1  horizontal sync.
- i_VSync  in  1  vertical sync.
- o_HSync  out  1  i_HSync delayed by one register.
- o_VSync  out  1  i_VSync delayed by one register.
- o_Col_Count  out  10  pixel column, 0..TOTAL_COLS-1.
- o_Row_Count  out  10  pixel row, 0..TOTAL_ROWS-1.
- o_Col_Count_Div  out  5  o_Col_Count[9:5].
- o_Row_Count_Div  out  5  o_Row_Count[9:5].
- o_Obj_X  out  6  current object tile X.
- o_Obj_Y  out  6  object tile Y; always equals c_INIT_Y.
- o_Step  out  1  one-cycle pulse on the clock edge where the position updates.
- o_Draw  out  1  combinational: high when o_Col_Count_Div==o_Obj_X and o_Row_Count_Div==o_Obj_Y (zero-extended compare).

Behaviour:
- Reset values (async, i_Rst=1):
  - o_HSync, o_VSync, both counters, o_Step, the tick counter: 0.
  - o_Obj_X = c_INIT_X.
  - o_Obj_Y = c_INIT_Y.
- Sync delay: o_HSync/o_VSync are registered copies of the inputs; latency is 1 clock.
- Frame start is defined as i_VSync==1 while o_VSync==0, i.e. a rising edge against the delayed copy.
- Counter update on each clock, in priority order:
  - On frame start: o_Col_Count=0 and o_Row_Count=0.
  - Else if o_Col_Count==TOTAL_COLS-1: o_Col_Count=0; o_Row_Count increments, or wraps to 0 if it was TOTAL_ROWS-1.
  - Else: o_Col_Count increments.
- Tile indices are pure bit slices of the counters; they add no latency.
- Tick counter, 32-bit:
  - Counts 0..c_SLOW_COUNT-1.
  - At c_SLOW_COUNT-1 it returns to 0 and a step occurs on that same edge.
  - The first step therefore happens c_SLOW_COUNT clocks after reset release.
- Step with c_DIR=0 (rightward):
  - If o_Obj_X + c_SPEED >= c_MAX_X: o_Obj_X = c_MIN_X.
  - Else: o_Obj_X += c_SPEED.
- Step with c_DIR=1 (leftward):
  - If o_Obj_X < c_MIN_X + c_SPEED: o_Obj_X = c_MAX_X-1.
  - Else: o_Obj_X -= c_SPEED.
- Arithmetic is done in 7 bits so sums and differences never wrap silently.
- o_Step is registered and is high for exactly the cycle following the updating edge, aligned with the new o_Obj_X.
- Motion is independent of the sync inputs. A frame start does not disturb the tick counter or the position.
- Reset asserted mid-operation immediately restores all reset values. Counting resumes from 0 on release.
- o_Draw is purely combinational; it has no reset dependency beyond its inputs.

Optional Feature:
- Macro LANE_PAUSE_EN.
- When defined, an extra input i_Enable (1 bit) is added:
  - While i_Enable==0 the tick counter and o_Obj_X hold their values and o_Step stays 0.
  - Sync delay and counters are unaffected.
- When undefined, the port is absent and the object always moves.

Test Plan:
- Reset and sync delay: hold i_Rst=1 -> all outputs 0 except o_Obj_X=c_INIT_X and o_Obj_Y=c_INIT_Y. Release, then toggle i_HSync -> o_HSync follows exactly 1 clock later.
- Counter wrap (TOTAL_COLS=8, TOTAL_ROWS=4), free-running with no VSync edge:
  - o_Col_Count goes 0..7 then 0.
  - o_Row_Count increments at each column wrap and returns from 3 to 0.
  - Drive a VSync rising edge mid-line -> both counters read 0 on the next cycle.
- Rightward wrap (c_SLOW_COUNT=4, c_INIT_X=12, c_MAX_X=14, c_DIR=0) -> o_Step pulses every 4 clocks; o_Obj_X sequence is 12, 13, 0, 1.
- Leftward wrap (c_SLOW_COUNT=4, c_INIT_X=1, c_MIN_X=0, c_MAX_X=14, c_DIR=1) -> o_Obj_X sequence is 1, 0, 13, 12.
- Draw flag: position the counters at column 64-95, row 352 with o_Obj_X=2 and c_INIT_Y=11 -> o_Draw=1. At column 96 -> o_Draw=0.
- With LANE_PAUSE_EN defined: drop i_Enable for 10 clocks -> o_Obj_X is frozen and there are no o_Step pulses. Raise it again -> stepping resumes with the remaining tick count.
